cntr_dn_reload_nb: RTL and testbench

CNTR_DN_RELOAD_NB -- requirements
Module: cntr_dn_reload_nb

---
 rtl/cntr_dn_reload_nb.sv | 65 ++++++
 tb/tb_cntr_dn_reload_nb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_dn_reload_nb.sv
// Down counter with reload register, one-shot or periodic countdown.
// done pulses once per terminal event; busy mirrors the RUN state.
module cntr_dn_reload_nb #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic         start,
    input  logic         dn,
    input  logic         mode,
    input  logic [n-1:0] D,
    output logic [n-1:0] count,
    output logic         rco,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic [n-1:0] rl;

    localparam logic [n-1:0] ZERO = '0;
    localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (clr) begin
            count <= ZERO;
            rl    <= ZERO;
            state <= IDLE;
        end else if (ld) begin
            count <= D;
            rl    <= D;
            if (state == RUN && D == ZERO)
                state <= IDLE;
        end else if (start && state == IDLE) begin
            if (rl != ZERO) begin
                count <= rl;
                state <= RUN;
            end
        end else if (state == RUN && dn) begin
            // terminal step: reload in periodic mode, stop in one-shot
            if (count > ONE) begin
                count <= count - ONE;
            end else if (count == ONE) begin
                done <= 1'b1;
                if (mode) begin
                    count <= rl;
                end else begin
                    count <= ZERO;
                    state <= IDLE;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign rco  = (count == ZERO);

endmodule

// File: tb/tb_cntr_dn_reload_nb.sv
// Directed bench for cntr_dn_reload_nb (n=8).
// Checks tuple {count, rco, busy, done} after each edge.
module tb_cntr_dn_reload_nb;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ld = 1'b0;
    logic       start = 1'b0;
    logic       dn = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] count;
    logic       rco;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    cntr_dn_reload_nb #(.n(8)) dut (
        .clk(clk),
        .clr(clr),
        .ld(ld),
        .start(start),
        .dn(dn),
        .mode(mode),
        .D(D),
        .count(count),
        .rco(rco),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; ld = 0; start = 0; dn = 0; mode = 0; D = 8'h00;
    endtask

    task automatic test_reset();
        clr = 1; ld = 1; D = 8'h55; start = 1; dn = 1;
        tick();
        idle_inputs();
        n_checks++;
        if ({count, rco, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got cnt=%0d rco=%b busy=%b done=%b want 0 1 0 0",
                     count, rco, busy, done);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] ec [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ld = 1; D = 8'd3;
        tick();
        ld = 0; start = 1; dn = 1; mode = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 0;
            n_checks++;
            if ({count, rco, busy, done} !==
                {ec[i], ec[i] == 8'd0, eb[i], ed[i]}) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got cnt=%0d rco=%b busy=%b done=%b want %0d %b %b",
                         i, count, rco, busy, done, ec[i], eb[i], ed[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_periodic();
        logic [7:0] exp;
        ld = 1; D = 8'd4;
        tick();
        ld = 0; mode = 1; start = 1; dn = 1;
        tick();
        start = 0;
        exp = 8'd4;
        n_checks++;
        if ({count, rco, busy, done} !== {8'd4, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL periodic_start: got cnt=%0d busy=%b done=%b want 4 1 0",
                     count, busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (exp == 8'd1) ? 8'd4 : exp - 8'd1;
            n_checks++;
            if ({count, rco, busy, done} !== {exp, 1'b0, 1'b1, exp == 8'd4}) begin
                n_fail++;
                $display("FAIL periodic[%0d]: got cnt=%0d rco=%b busy=%b done=%b want %0d 0 1 %b",
                         i, count, rco, busy, done, exp, exp == 8'd4);
            end
        end
        // switch to one-shot mid-run: next terminal step stops
        mode = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = exp - 8'd1;
            n_checks++;
            if ({count, busy, done} !== {exp, exp != 8'd0, exp == 8'd0}) begin
                n_fail++;
                $display("FAIL mode_switch[%0d]: got cnt=%0d busy=%b done=%b want %0d %b %b",
                         i, count, busy, done, exp, exp != 8'd0, exp == 8'd0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_gating();
        logic [7:0] ec [8] = '{8'd5, 8'd4, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
        logic       ev [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ld = 1; D = 8'd5;
        tick();
        ld = 0; start = 1; dn = 1;
        for (int i = 0; i < 8; i++) begin
            dn = ev[i];
            tick();
            start = 0;
            n_checks++;
            if ({count, busy, done} !== {ec[i], i != 7, i == 7}) begin
                n_fail++;
                $display("FAIL gating[%0d]: got cnt=%0d busy=%b done=%b want %0d %b %b",
                         i, count, busy, done, ec[i], i != 7, i == 7);
            end
        end
        idle_inputs();
    endtask

    task automatic test_zero_override();
        ld = 1; D = 8'd0;
        tick();
        ld = 0; start = 1; dn = 1;
        tick();
        start = 0;
        n_checks++;
        if ({count, rco, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_start: got cnt=%0d rco=%b busy=%b done=%b want 0 1 0 0",
                     count, rco, busy, done);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_start_after: got busy=%b done=%b want 0 0", busy, done);
        end
        ld = 1; D = 8'd5;
        tick();
        ld = 0; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        tick();
        n_checks++;
        if ({count, busy} !== {8'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL override_pre: got cnt=%0d busy=%b want 2 1", count, busy);
        end
        ld = 1; D = 8'd9;
        tick();
        ld = 0; dn = 0;
        n_checks++;
        if ({count, busy, done} !== {8'd9, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL override_ld9: got cnt=%0d busy=%b done=%b want 9 1 0",
                     count, busy, done);
        end
        ld = 1; D = 8'd0; dn = 1;
        tick();
        ld = 0;
        n_checks++;
        if ({count, rco, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL override_ld0: got cnt=%0d rco=%b busy=%b done=%b want 0 1 0 0",
                     count, rco, busy, done);
        end
        tick();
        n_checks++;
        if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL override_ld0_after: got cnt=%0d busy=%b done=%b want 0 0 0",
                     count, busy, done);
        end
        idle_inputs();
    endtask

    task automatic test_clr_priority();
        ld = 1; D = 8'd8;
        tick();
        ld = 0; start = 1; dn = 1;
        tick();
        tick();
        // start while running must not restart the count
        n_checks++;
        if ({count, busy} !== {8'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL start_in_run: got cnt=%0d busy=%b want 7 1", count, busy);
        end
        start = 0;
        tick();
        n_checks++;
        if (count !== 8'd6) begin
            n_fail++;
            $display("FAIL clr_pre: got cnt=%0d want 6", count);
        end
        clr = 1; ld = 1; D = 8'hFF;
        tick();
        clr = 0; ld = 0;
        n_checks++;
        if ({count, rco, busy, done} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_prio: got cnt=%0d rco=%b busy=%b done=%b want 0 1 0 0",
                     count, rco, busy, done);
        end
        start = 1;
        tick();
        start = 0;
        n_checks++;
        if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_then_start: got cnt=%0d busy=%b done=%b want 0 0 0",
                     count, busy, done);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_oneshot();
        test_periodic();
        test_gating();
        test_zero_override();
        test_clr_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
